// File: rtl/poly_mult_v2.sv
// poly_mult_v2: NTT-based negacyclic multiplier over Z_q[x]/(x^N+1), N = 2^RING_DEPTH.
// Define POLYMULT_OUT_BITREV_EN to stream C in bit-reversed index order (natural order otherwise).
module poly_mult_v2 #(
    parameter int RING_DEPTH = 4,
    parameter int DATA_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_transaction,
    input  logic [2:0]           mode,
    output logic                 busy,
    output logic                 done_all,
    input  logic                 valid_in,
    input  logic [DATA_SIZE-1:0] din,
    output logic                 fifo_rd_enable,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 valid_out,
    output logic                 fifo_wr_enable,
    input  logic                 fifo_full
);
    localparam int N   = 1 << RING_DEPTH;
    localparam int W   = DATA_SIZE;
    localparam int AW  = RING_DEPTH;
    localparam int CW  = RING_DEPTH + 2;
    localparam int MCW = $clog2(W);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD_TBL = 4'd1;
    localparam logic [3:0] S_LOAD_A   = 4'd2;
    localparam logic [3:0] S_LOAD_B   = 4'd3;
    localparam logic [3:0] S_NTT_A    = 4'd4;
    localparam logic [3:0] S_NTT_B    = 4'd5;
    localparam logic [3:0] S_PWMUL    = 4'd6;
    localparam logic [3:0] S_INTT     = 4'd7;
    localparam logic [3:0] S_SCALE    = 4'd8;
    localparam logic [3:0] S_OUTPUT   = 4'd9;
    localparam logic [3:0] S_DONE     = 4'd10;

    localparam logic [1:0] PH_LD  = 2'd0;
    localparam logic [1:0] PH_MUL = 2'd1;
    localparam logic [1:0] PH_WR  = 2'd2;

    logic [3:0]     state, next_state;
    logic [1:0]     phase;
    logic [CW-1:0]  cnt;
    logic [AW-1:0]  idx;
    logic [4:0]     stage;
    logic [W-1:0]   mul_a, mul_b, acc, acc_next, op_a, op_b;
    logic [MCW-1:0] mul_cnt;

    logic [W-1:0] ram_a   [N];
    logic [W-1:0] ram_b   [N];
    logic [W-1:0] psi     [N];
    logic [W-1:0] psi_inv [N];
    logic [W-1:0] q, ninv;

    logic [AW-1:0] t_len, grp, j_lo, ix_u, ix_v, ix_tw, last_idx, oaddr;
    logic [W-1:0]  x_u, x_v;
    logic          is_xform, tgt_b;

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[W]) d = d + {1'b0, m};
        return d[W-1:0];
    endfunction

`ifdef POLYMULT_OUT_BITREV_EN
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x);
        logic [AW-1:0] r;
        for (int unsigned k = 0; k < AW; k++) r[k] = x[AW-1-k];
        return r;
    endfunction
    assign oaddr = bitrev(idx);
`else
    assign oaddr = idx;
`endif

    // Butterfly addressing: idx enumerates the N/2 butterflies of the current stage.
    always_comb begin
        t_len = '0;
        grp   = '0;
        j_lo  = '0;
        ix_tw = '0;
        if (state == S_INTT) begin
            t_len = AW'(1) << stage;
            grp   = idx >> stage;
            j_lo  = (grp << (stage + 5'd1)) + (idx & (t_len - AW'(1)));
            ix_tw = (AW'(N/2) >> stage) + grp;
        end else begin
            t_len = AW'(N/2) >> stage;
            grp   = idx >> (AW - 1 - int'(stage));
            j_lo  = (grp << (AW - int'(stage))) + (idx & (t_len - AW'(1)));
            ix_tw = (AW'(1) << stage) + grp;
        end
        ix_u = j_lo;
        ix_v = j_lo + t_len;
        if (state == S_PWMUL || state == S_SCALE) begin
            ix_u = idx;
            ix_v = idx;
        end
    end

    always_comb begin
        tgt_b    = (state == S_NTT_B);
        is_xform = (state == S_NTT_A) || (state == S_NTT_B) || (state == S_INTT);
        last_idx = is_xform ? AW'(N/2 - 1) : AW'(N - 1);
        x_u      = tgt_b ? ram_b[ix_u] : ram_a[ix_u];
        x_v      = tgt_b ? ram_b[ix_v] : ram_a[ix_v];
        op_a     = '0;
        op_b     = '0;
        case (state)
            S_NTT_A, S_NTT_B: begin op_a = x_v;                 op_b = psi[ix_tw];     end
            S_INTT:           begin op_a = mod_sub(x_u, x_v, q); op_b = psi_inv[ix_tw]; end
            S_PWMUL:          begin op_a = ram_a[idx];          op_b = ram_b[idx];     end
            S_SCALE:          begin op_a = ram_a[idx];          op_b = ninv;           end
            default: ;
        endcase
        case (state)
            S_NTT_A: next_state = S_NTT_B;
            S_NTT_B: next_state = S_PWMUL;
            S_PWMUL: next_state = S_INTT;
            S_INTT:  next_state = S_SCALE;
            default: next_state = S_OUTPUT;
        endcase
        // MSB-first shift-add step: acc <- 2*acc + bit*a, each term reduced once.
        acc_next = mod_add(acc, acc, q);
        if (mul_b[W-1]) acc_next = mod_add(acc_next, mul_a, q);
    end

    assign busy           = (state != S_IDLE) && (state != S_DONE);
    assign done_all       = (state == S_DONE);
    assign fifo_rd_enable = (state == S_LOAD_TBL) || (state == S_LOAD_A) || (state == S_LOAD_B);
    assign fifo_wr_enable = (state == S_OUTPUT) && !fifo_full;
    assign valid_out      = fifo_wr_enable;
    assign dout           = fifo_wr_enable ? ram_a[oaddr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            phase   <= PH_LD;
            cnt     <= '0;
            idx     <= '0;
            stage   <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            acc     <= '0;
            mul_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_transaction) begin
                    cnt   <= '0;
                    idx   <= '0;
                    stage <= '0;
                    phase <= PH_LD;
                    case (mode)
                        3'd0: state <= S_LOAD_TBL;
                        3'd1: state <= S_LOAD_A;
                        3'd2: state <= S_LOAD_B;
                        3'd3: state <= S_NTT_A;
                        default: ;
                    endcase
                end
                S_LOAD_TBL: if (valid_in) begin
                    if (cnt == CW'(2*N + 1)) state <= S_IDLE;
                    cnt <= cnt + CW'(1);
                end
                S_LOAD_A, S_LOAD_B: if (valid_in) begin
                    if (cnt == CW'(N - 1)) state <= S_IDLE;
                    cnt <= cnt + CW'(1);
                end
                S_NTT_A, S_NTT_B, S_PWMUL, S_INTT, S_SCALE: begin
                    case (phase)
                        PH_LD: begin
                            mul_a   <= op_a;
                            mul_b   <= op_b;
                            acc     <= '0;
                            mul_cnt <= '0;
                            phase   <= PH_MUL;
                        end
                        PH_MUL: begin
                            acc     <= acc_next;
                            mul_b   <= mul_b << 1;
                            mul_cnt <= mul_cnt + MCW'(1);
                            if (mul_cnt == MCW'(W - 1)) phase <= PH_WR;
                        end
                        default: begin
                            phase <= PH_LD;
                            if (idx == last_idx) begin
                                idx <= '0;
                                if (is_xform && stage != 5'(RING_DEPTH - 1)) begin
                                    stage <= stage + 5'd1;
                                end else begin
                                    stage <= '0;
                                    state <= next_state;
                                end
                            end else begin
                                idx <= idx + AW'(1);
                            end
                        end
                    endcase
                end
                S_OUTPUT: if (fifo_wr_enable) begin
                    if (idx == AW'(N - 1)) state <= S_DONE;
                    idx <= idx + AW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage is not reset; writes are gated by the (reset) control state.
    always_ff @(posedge clk) begin
        if (state == S_LOAD_TBL && valid_in) begin
            if (cnt < CW'(N))          psi[cnt[AW-1:0]]     <= din;
            else if (cnt < CW'(2*N))   psi_inv[cnt[AW-1:0]] <= din;
            else if (cnt == CW'(2*N))  q                    <= din;
            else                       ninv                 <= din;
        end
        if (state == S_LOAD_A && valid_in) ram_a[cnt[AW-1:0]] <= din;
        if (state == S_LOAD_B && valid_in) ram_b[cnt[AW-1:0]] <= din;
        if (phase == PH_WR) begin
            case (state)
                S_NTT_A: begin
                    ram_a[ix_u] <= mod_add(x_u, acc, q);
                    ram_a[ix_v] <= mod_sub(x_u, acc, q);
                end
                S_NTT_B: begin
                    ram_b[ix_u] <= mod_add(x_u, acc, q);
                    ram_b[ix_v] <= mod_sub(x_u, acc, q);
                end
                S_INTT: begin
                    ram_a[ix_u] <= mod_add(x_u, x_v, q);
                    ram_a[ix_v] <= acc;
                end
                S_PWMUL, S_SCALE: ram_a[idx] <= acc;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_mult_v2.sv
// Directed bench for poly_mult_v2: q = 97, N = 16, psi = 28 (primitive 32nd root mod 97).
`timescale 1ns/1ps
module tb_poly_mult_v2;
    localparam int RD   = 4;
    localparam int N    = 16;
    localparam int W    = 16;
    localparam int Q    = 97;
    localparam int NINV = 91;
    localparam int PSI  = 28;
    localparam int LAT_MAX = (N * RD * 3 / 2 + 2 * N) * (W + 4);

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start_transaction = 1'b0;
    logic [2:0]   mode = '0;
    logic         valid_in = 1'b0;
    logic [W-1:0] din = '0;
    logic         fifo_full = 1'b0;
    logic         busy, done_all, fifo_rd_enable, valid_out, fifo_wr_enable;
    logic [W-1:0] dout;

    logic [W-1:0] pa [N];
    logic [W-1:0] pb [N];
    logic [W-1:0] exp_c [N];
    logic [W-1:0] stream [N];
    logic [W-1:0] got_c [N];

    int n_cmp = 0;
    int n_mis = 0;

    poly_mult_v2 #(.RING_DEPTH(RD), .DATA_SIZE(W)) dut (
        .clk(clk), .reset(reset), .start_transaction(start_transaction), .mode(mode),
        .busy(busy), .done_all(done_all), .valid_in(valid_in), .din(din),
        .fifo_rd_enable(fifo_rd_enable), .dout(dout), .valid_out(valid_out),
        .fifo_wr_enable(fifo_wr_enable), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int modpow(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % Q;
        return r;
    endfunction

    function automatic int brev(input int x);
        int r = 0;
        for (int k = 0; k < RD; k++) if (x[k]) r = r | (1 << (RD - 1 - k));
        return r;
    endfunction

    task automatic send_cmd(input logic [2:0] m);
        start_transaction = 1'b1;
        mode = m;
        @(negedge clk);
        start_transaction = 1'b0;
        mode = '0;
    endtask

    // gap: insert idle valid_in cycles and a stray start while the load is running
    task automatic load_words(input string tag, input logic [W-1:0] words[$], input bit gap);
        for (int i = 0; i < words.size(); i++) begin
            if (gap && (i % 3 == 1)) begin
                valid_in = 1'b0;
                if (i == 7) begin
                    start_transaction = 1'b1;
                    mode = 3'd3;
                end
                @(negedge clk);
                start_transaction = 1'b0;
                mode = '0;
                @(negedge clk);
            end
            valid_in = 1'b1;
            din = words[i];
            if (i == 0) check({tag, "_rd_en"}, fifo_rd_enable, 1);
            if (gap && i == words.size() - 1) check({tag, "_busy_before_last"}, busy, 1);
            @(negedge clk);
        end
        valid_in = 1'b0;
        check({tag, "_busy_after_last"}, busy, 0);
    endtask

    task automatic load_tables();
        logic [W-1:0] w[$];
        int psi_inv;
        psi_inv = modpow(PSI, 31);
        for (int k = 0; k < N; k++) w.push_back(W'(modpow(PSI, brev(k))));
        for (int k = 0; k < N; k++) w.push_back(W'(modpow(psi_inv, brev(k))));
        w.push_back(W'(Q));
        w.push_back(W'(NINV));
        send_cmd(3'd0);
        load_words("tbl", w, 1'b0);
    endtask

    task automatic load_ab(input bit gap);
        logic [W-1:0] wa[$];
        logic [W-1:0] wb[$];
        for (int k = 0; k < N; k++) begin
            wa.push_back(pa[k]);
            wb.push_back(pb[k]);
        end
        send_cmd(3'd1);
        load_words("load_a", wa, gap);
        send_cmd(3'd2);
        load_words("load_b", wb, 1'b0);
    endtask

    task automatic set_case(input int sel);
        for (int k = 0; k < N; k++) begin
            pa[k] = '0;
            pb[k] = '0;
            exp_c[k] = '0;
        end
        case (sel)
            0: begin  // (1+2x+3x^2)(2+2x) = 2+6x+10x^2+6x^3
                pa[0] = 1; pa[1] = 2; pa[2] = 3;
                pb[0] = 2; pb[1] = 2;
                exp_c[0] = 2; exp_c[1] = 6; exp_c[2] = 10; exp_c[3] = 6;
            end
            1: begin  // x^15 * x = x^16 = -1
                pa[15] = 1; pb[1] = 1;
                exp_c[0] = 96;
            end
            default: begin  // (x + 3x^10) * 5x^7 = 5x^8 + 15x^17 = 5x^8 - 15x
                pa[1] = 1; pa[10] = 3; pb[7] = 5;
                exp_c[1] = 82; exp_c[8] = 5;
            end
        endcase
    endtask

    task automatic run_go(input string tag, input bit stall);
        int nout = 0, ndone = 0, cyc = 0, lat = -1, stall_left = 0, bad_push = 0, tail = 0;
        bit stall_used = 1'b0;
        send_cmd(3'd3);
        while (cyc < 6000 && tail < 5) begin
            if (stall && nout == 5 && !stall_used) begin
                stall_used = 1'b1;
                stall_left = 20;
            end
            fifo_full = (stall_left > 0);
            start_transaction = (cyc == 10);
            mode = (cyc == 10) ? 3'd1 : 3'd0;
            #1;
            if (fifo_wr_enable) begin
                if (fifo_full) bad_push++;
                if (nout < N) stream[nout] = dout;
                nout++;
                if (lat < 0) lat = cyc;
            end
            if (done_all) begin
                ndone++;
                check({tag, "_busy_at_done"}, busy, 0);
            end
            if (stall_left > 0) stall_left--;
            if (ndone > 0) tail++;
            @(negedge clk);
            cyc++;
        end
        fifo_full = 1'b0;
        start_transaction = 1'b0;
        mode = '0;
        check({tag, "_done_pulses"}, ndone, 1);
        check({tag, "_word_count"}, nout, N);
        check({tag, "_latency_ok"}, (lat >= 0 && lat <= LAT_MAX), 1);
        if (stall) check({tag, "_push_while_full"}, bad_push, 0);
        for (int j = 0; j < N; j++) begin
`ifdef POLYMULT_OUT_BITREV_EN
            got_c[brev(j)] = stream[j];
`else
            got_c[j] = stream[j];
`endif
        end
        for (int k = 0; k < N; k++) check($sformatf("%s_c%0d", tag, k), got_c[k], exp_c[k]);
    endtask

    initial begin
        #12;
        check("reset_ctrl", {busy, done_all, valid_out, fifo_wr_enable, fifo_rd_enable}, 0);
        check("reset_dout", dout, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        send_cmd(3'd5);
        check("mode5_busy", busy, 0);
        check("mode5_rd_en", fifo_rd_enable, 0);
        @(negedge clk);
        check("mode5_busy_later", busy, 0);

        load_tables();

        set_case(0);
        load_ab(1'b0);
        run_go("basic", 1'b0);

        set_case(1);
        load_ab(1'b0);
        run_go("wrap", 1'b0);

        set_case(0);
        load_ab(1'b0);
        run_go("stall", 1'b1);

        set_case(2);
        load_ab(1'b1);
        run_go("gaps", 1'b0);

        set_case(0);
        load_ab(1'b0);
        send_cmd(3'd3);
        repeat (30) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("mid_reset_ctrl", {busy, done_all, valid_out, fifo_wr_enable, fifo_rd_enable}, 0);
        check("mid_reset_dout", dout, 0);
        repeat (3) @(negedge clk);
        check("mid_reset_busy_held", busy, 0);
        reset = 1'b1;
        @(negedge clk);
        load_ab(1'b0);
        run_go("after_reset", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/poly_mult_v2.md
# poly_mult_v2

Streaming negacyclic polynomial multiplier over Z_q[x]/(x^N+1), N = 2^RING_DEPTH, built on the number-theoretic transform (NTT). A host loads the twiddle tables and modulus, then operands A and B, through an input FIFO. It then issues GO; the block runs NTT(A), NTT(B), the pointwise product, the inverse NTT and the 1/N scaling, and streams C into an output FIFO. It sits between the host FIFO pair and the rest of the accelerator.

## Interface
- RING_DEPTH, 4, log2 of ring size N (N = 16).
- DATA_SIZE, 16, coefficient/word width W; requires q < 2^W.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_transaction  in  1  one-cycle command strobe, sampled in IDLE only.
- mode  in  3  command sampled with start_transaction:
  - 0 = load tables;
  - 1 = load A;
  - 2 = load B;
  - 3 = GO;
  - 4–7 = ignored.
- busy  out  1  high while a transaction is in progress.
- done_all  out  1  one-cycle pulse after the last C word is written (mode 3 only).
- valid_in  in  1  din valid; a word is consumed on every clock with valid_in=1 in a load state.
- din  in  W  input word.
- fifo_rd_enable  out  1  pop request to the input FIFO; high in every load state until its word count is reached.
- dout  out  W  output coefficient.
- valid_out  out  1  dout valid; equals fifo_wr_enable.
- fifo_wr_enable  out  1  push to the output FIFO.
- fifo_full  in  1  output FIFO full; stalls output.

## Operation
- States:
  - IDLE
  - LOAD_TBL
  - LOAD_A
  - LOAD_B
  - NTT_A
  - NTT_B
  - PWMUL
  - INTT
  - SCALE
  - OUTPUT
  - DONE
- start_transaction in IDLE with mode 0/1/2/3 goes to LOAD_TBL/LOAD_A/LOAD_B/NTT_A and sets busy. Modes 4–7, and any start outside IDLE, are ignored.
- LOAD_TBL consumes 2N+2 words in order:
  - psi[0..N-1]: powers of the primitive 2N-th root ψ, bit-reversed order, forward table;
  - psi_inv[0..N-1]: same ordering for ψ^-1;
  - q;
  - NINV = N^-1 mod q.
- LOAD_A and LOAD_B each consume N words, coefficient 0 first, into RAM A or RAM B.
- Every load state returns to IDLE after its last word; busy drops the next cycle.
- NTT_A and NTT_B run an in-place Cooley–Tukey forward negacyclic NTT, natural-order input, bit-reversed output. Per stage m = 1,2,4..N/2: for each group i, twiddle = psi[m+i]; butterfly (u, v·t) → (u+vt, u−vt).
- PWMUL: A[k] ← A[k]·B[k] mod q.
- INTT runs an in-place Gentleman–Sande inverse using psi_inv[m+i], stage m = N/2..1; butterfly (u, v) → (u+v, (u−v)·t). Output is natural order.
- SCALE: A[k] ← A[k]·NINV mod q.
- OUTPUT: the j-th written word (j = 0..N-1) is C[bitrev_RING_DEPTH(j)].
- DONE: pulses done_all for one cycle; busy is low in the same cycle; then IDLE.
- Arithmetic:
  - Operands < q; results fully reduced to [0, q).
  - Add/sub: W+1-bit intermediate, one conditional correction.
  - Modular multiply: bit-serial, MSB-first shift-add with conditional subtract; exactly W cycles per product.
  - One butterfly unit; operations do not overlap.
- A and B RAMs are overwritten by GO. Reload both before the next GO.

## Timing
- Reset values:
  - busy, done_all, valid_out, fifo_wr_enable, fifo_rd_enable = 0;
  - dout = 0;
  - state = IDLE.
- RAM and table contents are not reset.
- fifo_rd_enable rises the cycle after start is accepted. Words with valid_in=0 are skipped and the count holds.
- Compute latency, start to first output, is at most (N·RING_DEPTH·3/2 + 2N)·(W+4) cycles.
- Output: while fifo_full=1, no push occurs and the index holds. Back-to-back pushes otherwise, one word per cycle.
- Reset asserted mid-transaction: immediate return to IDLE, all outputs zero, partial load discarded (words already written remain).

## Configuration
- POLYMULT_OUT_BITREV_EN
  - Defined: output order is bit-reversed as specified above.
  - Undefined: output is in natural order, C[0] first.

## Test plan
- Setup: q = 97, N = 16, W = 16, ψ = a primitive 32nd root mod 97, macro defined.
- Load tables. Load A = 1+2x+3x², B = 2+2x. GO. Required C = 2+6x+10x²+6x³; all other coefficients 0; done_all pulses once.
- Negacyclic wrap: A = x^15, B = x. Required C[0] = 96 and every other coefficient 0.
- Hold fifo_full=1 for 20 cycles mid-output. Required: no pushes and no lost or duplicated words; result identical to the unstalled run.
- Interleave valid_in=0 gaps during LOAD_A. Required: exactly 16 words captured; busy falls only after the 16th word.
- Assert reset during NTT_A, then reload and GO. Required: outputs 0 during reset, then a correct product.
- Send start_transaction with mode=5, and a second start while busy. Required: both ignored; state unchanged.
